loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer_pkg.sv | 19 +
 rtl/loop_sequencer_counter.sv | 29 ++
 rtl/loop_sequencer.sv | 108 ++++++++++
 tb/tb_loop_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/loop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loop_sequencer_pkg
//  Description : Shared state encoding and default widths for loop_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package loop_sequencer_pkg;

    localparam int c_default_inner_width = 4;
    localparam int c_default_outer_width = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loop_sequencer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : loop_sequencer_counter
//  Description : Up-counter with synchronous clear; load_i advances the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_sequencer_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : loop_sequencer
//  Description : Two-level (inner/outer) loop index sequencer, one beat per
//                RUN cycle. Define LOOP_SEQUENCER_STALL_EN to honour stall_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_sequencer
    import loop_sequencer_pkg::*;
#(
    parameter int INNER_WIDTH = c_default_inner_width,
    parameter int OUTER_WIDTH = c_default_outer_width
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   stall_i,
    input  logic [INNER_WIDTH-1:0] inner_last_i,
    input  logic [OUTER_WIDTH-1:0] outer_last_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   beat_o,
    output logic                   last_o,
    output logic                   counter_rst_o,
    output logic [INNER_WIDTH-1:0] inner_idx_o,
    output logic [OUTER_WIDTH-1:0] outer_idx_o
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INNER_WIDTH-1:0] r_inner_last;
    logic [OUTER_WIDTH-1:0] r_outer_last;
    logic [OUTER_WIDTH-1:0] r_outer_idx;
    logic [INNER_WIDTH-1:0] w_inner_idx;
    logic                   w_stall;
    logic                   w_accept;
    logic                   w_beat;
    logic                   w_inner_wrap;
    logic                   w_last;
    logic                   w_inner_clr;

`ifdef LOOP_SEQUENCER_STALL_EN
    assign w_stall = stall_i;
`else
    logic w_unused_stall;
    assign w_unused_stall = stall_i;
    assign w_stall        = 1'b0;
`endif

    // Abort outranks both a pending start and an issuing beat.
    assign w_accept     = (r_state == S_IDLE) & start_i & ~abort_i;
    assign w_beat       = (r_state == S_RUN) & ~w_stall & ~abort_i;
    assign w_inner_wrap = w_beat & (w_inner_idx == r_inner_last);
    assign w_last       = w_inner_wrap & (r_outer_idx == r_outer_last);
    assign w_inner_clr  = rst_i | w_accept | w_inner_wrap;

    loop_sequencer_counter #(
        .WIDTH (INNER_WIDTH)
    ) u_inner_cnt (
        .clk_i   (clk_i),
        .rst_i   (w_inner_clr),
        .load_i  (w_beat),
        .count_o (w_inner_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_inner_last <= '0;
            r_outer_last <= '0;
            r_outer_idx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_inner_last <= inner_last_i;
                r_outer_last <= outer_last_i;
                r_outer_idx  <= '0;
            end else if (w_inner_wrap) begin
                // Final beat returns outer to zero so an all-ones limit never overflows.
                r_outer_idx <= w_last ? '0 : r_outer_idx + OUTER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   begin
                if (abort_i)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy_o        = (r_state == S_RUN);
    assign done_o        = (r_state == S_DONE);
    assign beat_o        = w_beat;
    assign last_o        = w_last;
    assign counter_rst_o = w_accept;
    assign inner_idx_o   = w_inner_idx;
    assign outer_idx_o   = r_outer_idx;

endmodule
`default_nettype wire

// File: tb/tb_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loop_sequencer
//  Description : Directed self-checking bench for loop_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       stall;
    logic [3:0] inner_last;
    logic [3:0] outer_last;
    logic       busy;
    logic       done;
    logic       beat;
    logic       last;
    logic       crst;
    logic [3:0] inner_idx;
    logic [3:0] outer_idx;

    int checks   = 0;
    int failures = 0;

    loop_sequencer #(
        .INNER_WIDTH (4),
        .OUTER_WIDTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .stall_i       (stall),
        .inner_last_i  (inner_last),
        .outer_last_i  (outer_last),
        .busy_o        (busy),
        .done_o        (done),
        .beat_o        (beat),
        .last_o        (last),
        .counter_rst_o (crst),
        .inner_idx_o   (inner_idx),
        .outer_idx_o   (outer_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index arguments below zero skip the index comparison.
    task automatic expect_out(input string tag, input logic e_busy, input logic e_done,
                              input logic e_beat, input logic e_last, input logic e_crst,
                              input int e_in, input int e_out);
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".beat"}, 32'(beat), 32'(e_beat));
        chk({tag, ".last"}, 32'(last), 32'(e_last));
        chk({tag, ".crst"}, 32'(crst), 32'(e_crst));
        if (e_in >= 0)  chk({tag, ".inner"}, 32'(inner_idx), 32'(e_in));
        if (e_out >= 0) chk({tag, ".outer"}, 32'(outer_idx), 32'(e_out));
    endtask

    int exp_in6[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_out6[6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        inner_last = 4'd0; outer_last = 4'd0;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);

        // 3x2 sweep: six beats, last on the sixth, done the cycle after
        @(negedge clk); rst = 1'b0; inner_last = 4'd2; outer_last = 4'd1; start = 1'b1;
        expect_out("t1.start", 0, 0, 0, 0, 1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); start = 1'b0;
            expect_out($sformatf("t1.beat%0d", k), 1, 0, 1, (k == 5), 0, exp_in6[k], exp_out6[k]);
        end
        @(negedge clk); expect_out("t1.done", 0, 1, 0, 0, 0, -1, -1);
        @(negedge clk); expect_out("t1.idle", 0, 0, 0, 0, 0, -1, -1);

        // 0/0 limits: single beat carrying last
        @(negedge clk); inner_last = 4'd0; outer_last = 4'd0; start = 1'b1;
        expect_out("t2.start", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0;
        expect_out("t2.beat", 1, 0, 1, 1, 0, 0, 0);
        @(negedge clk); expect_out("t2.done", 0, 1, 0, 0, 0, -1, -1);
        @(negedge clk); expect_out("t2.idle", 0, 0, 0, 0, 0, -1, -1);

        // Stall for three cycles at beat 2 of a 4x1 sweep
        @(negedge clk); inner_last = 4'd3; outer_last = 4'd0; start = 1'b1;
        expect_out("t3.start", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0;
        expect_out("t3.beat0", 1, 0, 1, 0, 0, 0, 0);
`ifdef LOOP_SEQUENCER_STALL_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); stall = 1'b1;
            expect_out($sformatf("t3.stall%0d", k), 1, 0, 0, 0, 0, 1, 0);
        end
        @(negedge clk); stall = 1'b0; expect_out("t3.beat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); expect_out("t3.beat2", 1, 0, 1, 0, 0, 2, 0);
        @(negedge clk); expect_out("t3.beat3", 1, 0, 1, 1, 0, 3, 0);
        @(negedge clk); expect_out("t3.done", 0, 1, 0, 0, 0, -1, -1);
`else
        @(negedge clk); stall = 1'b1; expect_out("t3.beat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); expect_out("t3.beat2", 1, 0, 1, 0, 0, 2, 0);
        @(negedge clk); expect_out("t3.beat3", 1, 0, 1, 1, 0, 3, 0);
        @(negedge clk); stall = 1'b0; expect_out("t3.done", 0, 1, 0, 0, 0, -1, -1);
`endif
        @(negedge clk); expect_out("t3.idle", 0, 0, 0, 0, 0, -1, -1);

        // Abort at beat 3 of a 16-beat sweep
        @(negedge clk); inner_last = 4'd3; outer_last = 4'd3; start = 1'b1;
        expect_out("t4.start", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0; expect_out("t4.beat0", 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk); expect_out("t4.beat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); abort = 1'b1; expect_out("t4.abort", 1, 0, 0, 0, 0, 2, 0);
        @(negedge clk); abort = 1'b0; expect_out("t4.idle0", 0, 0, 0, 0, 0, -1, -1);
        @(negedge clk); expect_out("t4.idle1", 0, 0, 0, 0, 0, -1, -1);

        // Start repeated and inner limit changed mid-sweep are ignored
        @(negedge clk); inner_last = 4'd1; outer_last = 4'd1; start = 1'b1;
        expect_out("t5.start", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0; expect_out("t5.beat0", 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk); start = 1'b1; inner_last = 4'd3;
        expect_out("t5.beat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); expect_out("t5.beat2", 1, 0, 1, 0, 0, 0, 1);
        @(negedge clk); expect_out("t5.beat3", 1, 0, 1, 1, 0, 1, 1);
        @(negedge clk); start = 1'b0; expect_out("t5.done", 0, 1, 0, 0, 0, -1, -1);
        @(negedge clk); expect_out("t5.idle", 0, 0, 0, 0, 0, -1, -1);

        // Reset mid-sweep, then a clean restart
        @(negedge clk); inner_last = 4'd2; outer_last = 4'd2; start = 1'b1;
        expect_out("t6.start", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0; expect_out("t6.beat0", 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk); expect_out("t6.beat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; expect_out("t6.rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); expect_out("t6.idle", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); start = 1'b1; expect_out("t6.restart", 0, 0, 0, 0, 1, -1, -1);
        @(negedge clk); start = 1'b0; expect_out("t6.rbeat0", 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk); expect_out("t6.rbeat1", 1, 0, 1, 0, 0, 1, 0);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0; expect_out("t6.end", 0, 0, 0, 0, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
